// File: rtl/rtc_bus_master_pkg.sv
// Shared definitions for the RTC multiplexed bus master: phase encodings,
// strobe polarity constants and the per-phase duration lookup.
package rtc_bus_master_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_A_SETUP = 3'd1,
    PH_A_PULSE = 3'd2,
    PH_A_HOLD  = 3'd3,
    PH_D_SETUP = 3'd4,
    PH_D_PULSE = 3'd5,
    PH_D_HOLD  = 3'd6,
    PH_RECOVER = 3'd7
  } phase_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;
  localparam logic AD_ADDR    = 1'b0;
  localparam logic AD_DATA    = 1'b1;

  // Number of clk cycles spent in a bus phase.
  function automatic int unsigned phase_cycles(input phase_e ph,
                                               input int unsigned t_setup,
                                               input int unsigned t_pulse,
                                               input int unsigned t_hold,
                                               input int unsigned t_rec);
    int unsigned cyc;
    case (ph)
      PH_A_SETUP, PH_D_SETUP: cyc = t_setup;
      PH_A_PULSE, PH_D_PULSE: cyc = t_pulse;
      PH_A_HOLD,  PH_D_HOLD:  cyc = t_hold;
      PH_RECOVER:             cyc = t_rec;
      default:                cyc = 1;
    endcase
    return cyc;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; expire_c marks the final cycle
// of the loaded interval.
module rtc_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // load_val is the phase length minus one; the counter idles once it hits zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_c = run_q && (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Command-driven master for the RTC multiplexed address/data bus: single or
// auto-incrementing burst reads/writes with programmable phase timing.
module rtc_bus_master
  import rtc_bus_master_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned MAX_BURST = 8,
  parameter  int unsigned T_SETUP   = 2,
  parameter  int unsigned T_PULSE   = 4,
  parameter  int unsigned T_HOLD    = 2,
  parameter  int unsigned T_REC     = 3,
  localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [DATA_W-1:0]           cmd_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic [DATA_W*MAX_BURST-1:0] wr_data,
  input  logic                        abort,
  output logic [DATA_W*MAX_BURST-1:0] rd_data,
  output logic                        done,
  output logic [LEN_W-1:0]            beats_done,
  output logic                        busy,
  input  logic [DATA_W-1:0]           bus_in,
  output logic [DATA_W-1:0]           bus_out,
  output logic                        bus_oe,
  output logic                        cs,
  output logic                        ad,
  output logic                        wr,
  output logic                        rd
);

  localparam int unsigned IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned T_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned T_HR  = (T_HOLD > T_REC) ? T_HOLD : T_REC;
  localparam int unsigned T_MAX = (T_SP > T_HR) ? T_SP : T_HR;
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  phase_e                               state_q, state_d;
  logic [LEN_W-1:0]                     beat_q, beat_d, beat_nxt;
  logic [LEN_W-1:0]                     len_q, len_d, len_clamp;
  logic [DATA_W-1:0]                    addr_q, addr_d;
  logic                                 write_q, write_d;
  logic                                 abort_q;
  logic [MAX_BURST-1:0][DATA_W-1:0]     wr_buf_q;
  logic [MAX_BURST-1:0][DATA_W-1:0]     rd_buf_q;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic                                 accept_c;
  logic                                 expire_c;
  logic                                 load;
  logic [CNT_W-1:0]                     load_val;
  logic                                 done_d;
  logic [LEN_W-1:0]                     beats_done_d;
  logic                                 cs_d, ad_d, wr_d, rd_d, oe_d;
  logic [DATA_W-1:0]                    bus_out_d;
  logic                                 in_data_c, in_addr_c;

  assign accept_c  = cmd_valid && cmd_ready;
  assign beat_nxt  = beat_q + LEN_W'(1);
  assign len_clamp = (cmd_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : cmd_len;
  assign idx_q     = beat_q[IDX_W-1:0];
  assign idx_d     = beat_d[IDX_W-1:0];
  assign rd_data   = rd_buf_q;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire_c (expire_c)
  );

  // Next-state, beat bookkeeping and next values of the registered bus outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    len_d        = len_q;
    addr_d       = addr_q;
    write_d      = write_q;
    done_d       = 1'b0;
    beats_done_d = beats_done;

    case (state_q)
      PH_IDLE: begin
        if (accept_c) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          beat_d  = '0;
          len_d   = len_clamp;
          if (len_clamp == '0) begin
            done_d       = 1'b1;
            beats_done_d = '0;
          end else begin
            state_d = PH_A_SETUP;
          end
        end
      end
      PH_A_SETUP: if (expire_c) state_d = PH_A_PULSE;
      PH_A_PULSE: if (expire_c) state_d = PH_A_HOLD;
      PH_A_HOLD:  if (expire_c) state_d = PH_D_SETUP;
      PH_D_SETUP: if (expire_c) state_d = PH_D_PULSE;
      PH_D_PULSE: if (expire_c) state_d = PH_D_HOLD;
      PH_D_HOLD:  if (expire_c) state_d = PH_RECOVER;
      PH_RECOVER: begin
        if (expire_c) begin
          // abort is also honoured on the very last RECOVER cycle
          if ((beat_nxt >= len_q) || abort_q || abort) begin
            state_d      = PH_IDLE;
            done_d       = 1'b1;
            beats_done_d = beat_nxt;
          end else begin
            state_d = PH_A_SETUP;
            beat_d  = beat_nxt;
            addr_d  = addr_q + DATA_W'(1);
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase

    load     = (state_d != state_q) && (state_d != PH_IDLE);
    load_val = CNT_W'(phase_cycles(state_d, T_SETUP, T_PULSE, T_HOLD, T_REC) - 1);

    in_addr_c = (state_d == PH_A_SETUP) || (state_d == PH_A_PULSE) || (state_d == PH_A_HOLD);
    in_data_c = (state_d == PH_D_SETUP) || (state_d == PH_D_PULSE) || (state_d == PH_D_HOLD);

    cs_d      = (in_addr_c || in_data_c) ? STROBE_ON : STROBE_OFF;
    ad_d      = in_data_c ? AD_DATA : AD_ADDR;
    wr_d      = ((state_d == PH_A_PULSE) || ((state_d == PH_D_PULSE) && write_d))
                ? STROBE_ON : STROBE_OFF;
    rd_d      = ((state_d == PH_D_PULSE) && !write_d) ? STROBE_ON : STROBE_OFF;
    oe_d      = in_addr_c || (in_data_c && write_d);
    bus_out_d = '0;
    if (in_addr_c)                 bus_out_d = addr_d;
    else if (in_data_c && write_d) bus_out_d = wr_buf_q[idx_d];
  end

  // FSM state and command context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PH_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      if (accept_c)                          abort_q <= 1'b0;
      else if (abort && (state_q != PH_IDLE)) abort_q <= 1'b1;
    end
  end

  // Write payload captured at accept; read beats sampled on the last rd-low cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_buf_q <= '0;
      rd_buf_q <= '0;
    end else begin
      if (accept_c) wr_buf_q <= wr_data;
      if (accept_c && !cmd_write) begin
        rd_buf_q <= '0;
      end else if ((state_q == PH_D_PULSE) && expire_c && !write_q) begin
        rd_buf_q[idx_q] <= bus_in;
      end
    end
  end

  // Registered bus and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs         <= STROBE_OFF;
      wr         <= STROBE_OFF;
      rd         <= STROBE_OFF;
      ad         <= AD_ADDR;
      bus_oe     <= 1'b0;
      bus_out    <= '0;
      done       <= 1'b0;
      beats_done <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      cs         <= cs_d;
      wr         <= wr_d;
      rd         <= rd_d;
      ad         <= ad_d;
      bus_oe     <= oe_d;
      bus_out    <= bus_out_d;
      done       <= done_d;
      beats_done <= beats_done_d;
      cmd_ready  <= (state_d == PH_IDLE);
      busy       <= (state_d != PH_IDLE);
    end
  end

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master at default parameters with a simple
// register device on the bus that returns addr ^ 0xFF on reads.
module tb_rtc_bus_master;

  localparam int BEAT = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [3:0]  cmd_len = 4'd0;
  logic [63:0] wr_data = 64'h0;
  logic        abort = 1'b0;
  logic [63:0] rd_data;
  logic        done;
  logic [3:0]  beats_done;
  logic        busy;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        cs, ad, wr, rd;

  int checks = 0;
  int errors = 0;

  rtc_bus_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_data    (wr_data),
    .abort      (abort),
    .rd_data    (rd_data),
    .done       (done),
    .beats_done (beats_done),
    .busy       (busy),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .cs         (cs),
    .ad         (ad),
    .wr         (wr),
    .rd         (rd)
  );

  always #5 clk = ~clk;

  // Bus monitor and device model, sampled mid-cycle.
  int         cs_low_n = 0, cs_fall_n = 0, viol_n = 0, trunc_n = 0;
  int         wr_run = 0, rd_run = 0;
  logic       prev_cs = 1'b1;
  logic [7:0] dev_addr = 8'h00, last_wr_addr = 8'h00, last_wr_data = 8'h00;

  always @(negedge clk) begin
    if (!cs) cs_low_n++;
    if (prev_cs && !cs) cs_fall_n++;
    prev_cs = cs;
    if (!rd && bus_oe) viol_n++;
    if (!rd && !wr) viol_n++;
    if (!wr) wr_run++;
    else begin
      if (wr_run != 0 && wr_run != 4) trunc_n++;
      wr_run = 0;
    end
    if (!rd) rd_run++;
    else begin
      if (rd_run != 0 && rd_run != 4) trunc_n++;
      rd_run = 0;
    end
    if (!cs && !ad && bus_oe) dev_addr = bus_out;
    if (!cs && !wr && bus_oe) begin
      if (!ad) last_wr_addr = bus_out;
      else     last_wr_data = bus_out;
    end
  end

  assign bus_in = rd ? 8'h00 : (dev_addr ^ 8'hFF);

  task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l,
                       input logic [63:0] d);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_write = w; cmd_addr = a; cmd_len = l; wr_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts cycles from accept until done is seen; optionally pulses abort.
  task automatic wait_done(input int abort_at, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      abort = (abort_at != 0 && n == abort_at);
    end while (!done && n < 400);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cs, wr, rd, ad, bus_oe} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_strobes: cs/wr/rd/ad/oe=%b required 11100", {cs, wr, rd, ad, bus_oe});
    end
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_handshake: done/busy/ready=%b required 001", {done, busy, cmd_ready});
    end
    checks++;
    if (bus_out !== 8'h00 || rd_data !== 64'h0 || beats_done !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: bus_out=%h rd_data=%h beats_done=%0d required 0", bus_out, rd_data, beats_done);
    end
  endtask

  task automatic test_single_write;
    int n, l0, f0, t0;
    l0 = cs_low_n; f0 = cs_fall_n; t0 = trunc_n;
    issue(1'b1, 8'h21, 4'd1, 64'h45);
    wait_done(0, n);
    checks++;
    if (n !== BEAT + 1) begin
      errors++;
      $display("FAIL wr1_latency: done at cycle %0d required %0d", n, BEAT + 1);
    end
    checks++;
    if (cs_low_n - l0 !== 16 || cs_fall_n - f0 !== 1) begin
      errors++;
      $display("FAIL wr1_cs: low=%0d falls=%0d required 16 and 1", cs_low_n - l0, cs_fall_n - f0);
    end
    checks++;
    if (last_wr_addr !== 8'h21 || last_wr_data !== 8'h45) begin
      errors++;
      $display("FAIL wr1_bus: addr=%h data=%h required 21 45", last_wr_addr, last_wr_data);
    end
    checks++;
    if (beats_done !== 4'd1 || trunc_n != t0) begin
      errors++;
      $display("FAIL wr1_beats: beats_done=%0d trunc=%0d required 1 and 0", beats_done, trunc_n - t0);
    end
  endtask

  task automatic test_read_wrap;
    int n, v0;
    v0 = viol_n;
    issue(1'b0, 8'hFE, 4'd3, 64'h0);
    wait_done(0, n);
    checks++;
    if (rd_data !== 64'h0000_0000_00FF_0001) begin
      errors++;
      $display("FAIL rd3_data: rd_data=%h required 0000000000ff0001", rd_data);
    end
    checks++;
    if (beats_done !== 4'd3 || n !== 3 * BEAT + 1) begin
      errors++;
      $display("FAIL rd3_done: beats_done=%0d cycle=%0d required 3 and %0d", beats_done, n, 3 * BEAT + 1);
    end
    checks++;
    if (viol_n != v0) begin
      errors++;
      $display("FAIL rd3_oe_rd: %0d overlap cycles required 0", viol_n - v0);
    end
  endtask

  task automatic test_len_edges;
    int n, f0;
    f0 = cs_fall_n;
    issue(1'b1, 8'h55, 4'd0, 64'h0);
    wait_done(0, n);
    checks++;
    if (n !== 1 || beats_done !== 4'd0 || cs_fall_n != f0) begin
      errors++;
      $display("FAIL len0: cycle=%0d beats=%0d falls=%0d required 1 0 0", n, beats_done, cs_fall_n - f0);
    end
    f0 = cs_fall_n;
    issue(1'b1, 8'hA0, 4'd12, 64'h8877_6655_4433_2211);
    wait_done(0, n);
    checks++;
    if (beats_done !== 4'd8 || n !== 8 * BEAT + 1 || cs_fall_n - f0 !== 8) begin
      errors++;
      $display("FAIL len12: beats=%0d cycle=%0d falls=%0d required 8 %0d 8", beats_done, n, cs_fall_n - f0, 8 * BEAT + 1);
    end
    checks++;
    if (last_wr_addr !== 8'hA7 || last_wr_data !== 8'h88) begin
      errors++;
      $display("FAIL len12_last: addr=%h data=%h required a7 88", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_abort;
    int n, t0;
    t0 = trunc_n;
    issue(1'b0, 8'h10, 4'd4, 64'h0);
    // beat 1 D_PULSE spans cycles 30..33 after accept
    wait_done(31, n);
    checks++;
    if (beats_done !== 4'd2 || n !== 2 * BEAT + 1) begin
      errors++;
      $display("FAIL abort_done: beats=%0d cycle=%0d required 2 %0d", beats_done, n, 2 * BEAT + 1);
    end
    checks++;
    if (rd_data !== 64'h0000_0000_0000_EEEF || trunc_n != t0) begin
      errors++;
      $display("FAIL abort_data: rd_data=%h trunc=%0d required 000000000000eeef 0", rd_data, trunc_n - t0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    issue(1'b1, 8'h60, 4'd1, 64'h77);
    repeat (4) @(negedge clk);
    checks++;
    if (wr !== 1'b0 || cs !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: cs=%b wr=%b required 0 0", cs, wr);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({cs, wr, rd, bus_oe, busy, cmd_ready} !== 6'b111001) begin
      errors++;
      $display("FAIL rstmid_release: cs/wr/rd/oe/busy/ready=%b required 111001", {cs, wr, rd, bus_oe, busy, cmd_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    issue(1'b1, 8'h33, 4'd1, 64'h5A);
    wait_done(0, n);
    checks++;
    if (n !== BEAT + 1 || beats_done !== 4'd1 || last_wr_addr !== 8'h33 || last_wr_data !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_after: cycle=%0d beats=%0d addr=%h data=%h required %0d 1 33 5a", n, beats_done, last_wr_addr, last_wr_data, BEAT + 1);
    end
  endtask

  task automatic test_back_to_back;
    int n, f0;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd2; wr_data = 64'h2211; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_addr = 8'h70; cmd_len = 4'd1; wr_data = 64'h99;
    f0 = cs_fall_n;
    wait_done(0, n);
    checks++;
    if (n !== 2 * BEAT + 1 || beats_done !== 4'd2 || cs_fall_n - f0 !== 2) begin
      errors++;
      $display("FAIL b2b_first: cycle=%0d beats=%0d falls=%0d required %0d 2 2", n, beats_done, cs_fall_n - f0, 2 * BEAT + 1);
    end
    checks++;
    if (last_wr_addr !== 8'h41 || last_wr_data !== 8'h22) begin
      errors++;
      $display("FAIL b2b_first_bus: addr=%h data=%h required 41 22", last_wr_addr, last_wr_data);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cs !== 1'b0 || bus_out !== 8'h70) begin
      errors++;
      $display("FAIL b2b_start: cs=%b bus_out=%h required 0 70", cs, bus_out);
    end
    wait_done(0, n);
    checks++;
    if (n !== BEAT || last_wr_addr !== 8'h70 || last_wr_data !== 8'h99) begin
      errors++;
      $display("FAIL b2b_second: cycle=%0d addr=%h data=%h required %0d 70 99", n, last_wr_addr, last_wr_data, BEAT);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wrap;
    test_len_edges;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
